// File: rtl/apb_gpio32_pkg.sv
// rtl/apb_gpio32_pkg.sv - register map and shared helpers for the APB GPIO block
package apb_gpio32_pkg;

  localparam logic [7:0] ODR_OFS  = 8'h00;
  localparam logic [7:0] DIR_OFS  = 8'h04;
  localparam logic [7:0] AFC_OFS  = 8'h08;
  localparam logic [7:0] IDR_OFS  = 8'h0C;
  localparam logic [7:0] PML_OFS  = 8'h10;
  localparam logic [7:0] PMH_OFS  = 8'h14;
  localparam logic [7:0] PSL_OFS  = 8'h18;
  localparam logic [7:0] PSH_OFS  = 8'h1C;
  localparam logic [7:0] SET_OFS  = 8'h20;
  localparam logic [7:0] CLR_OFS  = 8'h24;
  localparam logic [7:0] TGL_OFS  = 8'h28;
  localparam logic [7:0] IE_OFS   = 8'h2C;
  localparam logic [7:0] RISE_OFS = 8'h30;
  localparam logic [7:0] FALL_OFS = 8'h34;
  localparam logic [7:0] IF_OFS   = 8'h38;

  localparam int REG_COUNT = 15;

  // Write-1-to-clear with new events taking priority over the clear.
  function automatic logic [31:0] w1c_update(input logic [31:0] cur,
                                             input logic [31:0] clr_mask,
                                             input logic [31:0] set_mask);
    return (cur & ~clr_mask) | set_mask;
  endfunction

endpackage

// File: rtl/apb_gpio32_in_sync_edge.sv
// rtl/apb_gpio32_in_sync_edge.sv - pin readback synchroniser and per-pin edge detector
module gpio_in_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  output logic [WIDTH-1:0] idr_o,
  output logic [WIDTH-1:0] edge_pulse_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign idr_o        = sync_q[SYNC_STAGES-1];
  assign edge_pulse_o = (idr_o & ~prev_q & rise_en_i) | (~idr_o & prev_q & fall_en_i);

endmodule

// File: rtl/apb_gpio32.sv
// rtl/apb_gpio32.sv - APB3 GPIO controller driving the AFIO pin mux
module apb_gpio32
  import apb_gpio32_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RST_AFC     = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [31:0]       GPIO_DI,
  output logic [31:0]       GPIO_DIR,
  output logic [31:0]       GPIO_AFC,
  output logic [63:0]       GPIO_PM,
  output logic [63:0]       GPIO_PS,
  input  logic [31:0]       GPIO_DO,
  output logic              IRQ
);

  logic [31:0] odr_q, odr_d, dir_q, dir_d, afc_q, afc_d;
  logic [63:0] pm_q, pm_d, ps_q, ps_d;
  logic [31:0] ie_q, ie_d, rise_q, rise_d, fall_q, fall_d, if_q, if_d;
  logic        irq_q, irq_d;
  logic [31:0] idr, edge_pulse, w1c_mask, rdata;
  logic [7:0]  ofs;
  logic        unmapped, access, err, wr_en;
  logic        unused_paddr;

  assign ofs          = {PADDR[7:2], 2'b00};
  assign unused_paddr = ^PADDR;
  assign unmapped     = int'(ofs[7:2]) >= REG_COUNT;
  assign access       = PSEL & PENABLE;
  assign err          = unmapped | (PWRITE & (ofs == IDR_OFS));
  assign wr_en        = access & PWRITE & ~err;

  gpio_in_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (32)
  ) u_in (
    .clk          (clk),
    .rst_n        (rst_n),
    .async_i      (GPIO_DO),
    .rise_en_i    (rise_q),
    .fall_en_i    (fall_q),
    .idr_o        (idr),
    .edge_pulse_o (edge_pulse)
  );

  always_comb begin
    odr_d    = odr_q;
    dir_d    = dir_q;
    afc_d    = afc_q;
    pm_d     = pm_q;
    ps_d     = ps_q;
    ie_d     = ie_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    w1c_mask = '0;
    if (wr_en) begin
      case (ofs)
        ODR_OFS:  odr_d         = PWDATA;
        DIR_OFS:  dir_d         = PWDATA;
        AFC_OFS:  afc_d         = PWDATA;
        PML_OFS:  pm_d[31:0]    = PWDATA;
        PMH_OFS:  pm_d[63:32]   = PWDATA;
        PSL_OFS:  ps_d[31:0]    = PWDATA;
        PSH_OFS:  ps_d[63:32]   = PWDATA;
        SET_OFS:  odr_d         = odr_q | PWDATA;
        CLR_OFS:  odr_d         = odr_q & ~PWDATA;
        TGL_OFS:  odr_d         = odr_q ^ PWDATA;
        IE_OFS:   ie_d          = PWDATA;
        RISE_OFS: rise_d        = PWDATA;
        FALL_OFS: fall_d        = PWDATA;
        IF_OFS:   w1c_mask      = PWDATA;
        default:  ;
      endcase
    end
    if_d  = w1c_update(if_q, w1c_mask, edge_pulse);
    irq_d = |(if_q & ie_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odr_q  <= '0;
      dir_q  <= '0;
      afc_q  <= RST_AFC;
      pm_q   <= '0;
      ps_q   <= '0;
      ie_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      if_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      odr_q  <= odr_d;
      dir_q  <= dir_d;
      afc_q  <= afc_d;
      pm_q   <= pm_d;
      ps_q   <= ps_d;
      ie_q   <= ie_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      if_q   <= if_d;
      irq_q  <= irq_d;
    end
  end

  // Write-only and unmapped offsets fall through to zero.
  always_comb begin
    rdata = '0;
    case (ofs)
      ODR_OFS:  rdata = odr_q;
      DIR_OFS:  rdata = dir_q;
      AFC_OFS:  rdata = afc_q;
      IDR_OFS:  rdata = idr;
      PML_OFS:  rdata = pm_q[31:0];
      PMH_OFS:  rdata = pm_q[63:32];
      PSL_OFS:  rdata = ps_q[31:0];
      PSH_OFS:  rdata = ps_q[63:32];
      IE_OFS:   rdata = ie_q;
      RISE_OFS: rdata = rise_q;
      FALL_OFS: rdata = fall_q;
      IF_OFS:   rdata = if_q;
      default:  rdata = '0;
    endcase
  end

  // Gated by rst_n so the bus outputs drop to zero the moment reset asserts.
  assign PRDATA   = (rst_n && PSEL) ? rdata : 32'h0;
  assign PSLVERR  = rst_n & access & err;
  assign PREADY   = 1'b1;
  assign GPIO_DI  = odr_q;
  assign GPIO_DIR = dir_q;
  assign GPIO_AFC = afc_q;
  assign GPIO_PM  = pm_q;
  assign GPIO_PS  = ps_q;
  assign IRQ      = irq_q;

endmodule
